// File: rtl/control_logic_pkg.sv
// Shared types and constants for the 8259A control logic: sequencer states,
// CPU write command classes and the bit positions that classify a write.
package control_logic_pkg;

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } seq_state_t;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ICW1 = 3'd1,
    OCW2 = 3'd2,
    OCW3 = 3'd3,
    DATA = 3'd4
  } cmd_class_t;

  localparam int ICW1_FLAG_BIT = 4;
  localparam int OCW3_FLAG_BIT = 3;
  localparam int SNGL_BIT      = 1;
  localparam int IC4_BIT       = 0;

  // Strobe vector layout used inside the sequencer
  localparam int STROBE_W = 7;
  localparam int STB_ICW1 = 0;
  localparam int STB_ICW2 = 1;
  localparam int STB_ICW3 = 2;
  localparam int STB_ICW4 = 3;
  localparam int STB_OCW1 = 4;
  localparam int STB_OCW2 = 5;
  localparam int STB_OCW3 = 6;

  function automatic logic is_busy(input seq_state_t st);
    logic busy;
    case (st)
      WAIT_ICW2, WAIT_ICW3, WAIT_ICW4: busy = 1'b1;
      default:                         busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/command_word_decoder.sv
// Combinational classification of a CPU write into ICW1 / OCW2 / OCW3 / data
// word, or NONE when no write is presented this cycle.
module command_word_decoder
  import control_logic_pkg::*;
(
  input  logic       write_strobe,
  input  logic       address_0,
  input  logic [7:0] internal_data_bus,
  output cmd_class_t command_class
);

  // Classify the write; A0=1 always carries a data word whose meaning the FSM decides
  always_comb begin
    command_class = NONE;
    if (write_strobe) begin
      if (address_0) begin
        command_class = DATA;
      end else if (internal_data_bus[ICW1_FLAG_BIT]) begin
        command_class = ICW1;
      end else if (internal_data_bus[OCW3_FLAG_BIT]) begin
        command_class = OCW3;
      end else begin
        command_class = OCW2;
      end
    end else begin
      command_class = NONE;
    end
  end

endmodule

// File: rtl/initialization_command_sequencer.sv
// 8259A initialization sequencer: walks ICW1->ICW2->[ICW3]->[ICW4]->ready and
// issues one registered write strobe per accepted ICW/OCW write.
module initialization_command_sequencer
  import control_logic_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic       address_0,
  input  logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       single_or_cascade_config,
  output logic       set_icw4_config,
  output logic       initialization_busy
);

  cmd_class_t          cmd_class_s;
  seq_state_t          state_r;
  seq_state_t          next_state_s;
  logic [STROBE_W-1:0] strobe_r;
  logic [STROBE_W-1:0] strobe_next_s;
  logic                sngl_r;
  logic                sngl_next_s;
  logic                ic4_r;
  logic                ic4_next_s;
  logic                busy_r;

  command_word_decoder u_decoder (
    .write_strobe      (write_strobe),
    .address_0         (address_0),
    .internal_data_bus (internal_data_bus),
    .command_class     (cmd_class_s)
  );

  // Next-state, next-strobe and configuration-latch logic
  always_comb begin
    next_state_s  = state_r;
    strobe_next_s = {STROBE_W{1'b0}};
    sngl_next_s   = sngl_r;
    ic4_next_s    = ic4_r;
    case (cmd_class_s)
      ICW1: begin
        // ICW1 restarts the sequence from any state, using the freshly written config
        strobe_next_s[STB_ICW1] = 1'b1;
        sngl_next_s             = internal_data_bus[SNGL_BIT];
        ic4_next_s              = internal_data_bus[IC4_BIT];
        next_state_s            = WAIT_ICW2;
      end
      DATA: begin
        case (state_r)
          WAIT_ICW2: begin
            strobe_next_s[STB_ICW2] = 1'b1;
            if (!sngl_r) begin
              next_state_s = WAIT_ICW3;
            end else if (ic4_r) begin
              next_state_s = WAIT_ICW4;
            end else begin
              next_state_s = READY;
            end
          end
          WAIT_ICW3: begin
            strobe_next_s[STB_ICW3] = 1'b1;
            if (ic4_r) begin
              next_state_s = WAIT_ICW4;
            end else begin
              next_state_s = READY;
            end
          end
          WAIT_ICW4: begin
            strobe_next_s[STB_ICW4] = 1'b1;
            next_state_s            = READY;
          end
          READY: begin
            strobe_next_s[STB_OCW1] = 1'b1;
          end
          default: begin
            next_state_s = state_r;
          end
        endcase
      end
      OCW2: begin
        if (state_r == READY) begin
          strobe_next_s[STB_OCW2] = 1'b1;
        end else begin
          strobe_next_s = {STROBE_W{1'b0}};
        end
      end
      OCW3: begin
        if (state_r == READY) begin
          strobe_next_s[STB_OCW3] = 1'b1;
        end else begin
          strobe_next_s = {STROBE_W{1'b0}};
        end
      end
      default: begin
        next_state_s = state_r;
      end
    endcase
  end

  // State, strobe and configuration registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= UNINIT;
      strobe_r <= {STROBE_W{1'b0}};
      sngl_r   <= 1'b0;
      ic4_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      strobe_r <= strobe_next_s;
      sngl_r   <= sngl_next_s;
      ic4_r    <= ic4_next_s;
      busy_r   <= is_busy(next_state_s);
    end
  end

  assign write_initial_command_word_1   = strobe_r[STB_ICW1];
  assign write_initial_command_word_2   = strobe_r[STB_ICW2];
  assign write_initial_command_word_3   = strobe_r[STB_ICW3];
  assign write_initial_command_word_4   = strobe_r[STB_ICW4];
  assign write_operation_control_word_1 = strobe_r[STB_OCW1];
  assign write_operation_control_word_2 = strobe_r[STB_OCW2];
  assign write_operation_control_word_3 = strobe_r[STB_OCW3];
  assign single_or_cascade_config       = sngl_r;
  assign set_icw4_config                = ic4_r;
  assign initialization_busy            = busy_r;

endmodule

// File: tb/tb_initialization_command_sequencer.sv
// Directed plus randomized bench for the initialization command sequencer,
// checked against a queue-based model of the expected ICW sequence.
module tb_initialization_command_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_strobe = 1'b0;
  logic       address_0 = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw2, w_ocw3;
  logic       sngl, ic4, busy;

  int checks = 0;
  int failures = 0;

  // Model: after ICW1, the list of ICW numbers still owed before the device is ready
  bit seen_icw1 = 1'b0;
  int pending[$];
  bit m_sngl = 1'b0;
  bit m_ic4 = 1'b0;

  initialization_command_sequencer dut (
    .clock                          (clock),
    .reset                          (reset),
    .write_strobe                   (write_strobe),
    .address_0                      (address_0),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (w_icw1),
    .write_initial_command_word_2   (w_icw2),
    .write_initial_command_word_3   (w_icw3),
    .write_initial_command_word_4   (w_icw4),
    .write_operation_control_word_1 (w_ocw1),
    .write_operation_control_word_2 (w_ocw2),
    .write_operation_control_word_3 (w_ocw3),
    .single_or_cascade_config       (sngl),
    .set_icw4_config                (ic4),
    .initialization_busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dut_strobes();
    return {w_ocw3, w_ocw2, w_ocw1, w_icw4, w_icw3, w_icw2, w_icw1};
  endfunction

  function automatic void model_reset();
    seen_icw1 = 1'b0;
    pending.delete();
    m_sngl = 1'b0;
    m_ic4 = 1'b0;
  endfunction

  // Returns the expected strobe vector (bit0=ICW1..bit3=ICW4, bit4..6=OCW1..3)
  function automatic logic [6:0] model_write(input bit ws, input bit a0, input logic [7:0] d);
    logic [6:0] exp;
    int n;
    bit ready;
    exp = 7'd0;
    ready = seen_icw1 && (pending.size() == 0);
    if (ws) begin
      if (!a0 && d[4]) begin
        exp[0] = 1'b1;
        seen_icw1 = 1'b1;
        m_sngl = d[1];
        m_ic4 = d[0];
        pending.delete();
        pending.push_back(2);
        if (!d[1]) pending.push_back(3);
        if (d[0]) pending.push_back(4);
      end else if (a0) begin
        if (pending.size() > 0) begin
          n = pending.pop_front();
          exp[n-1] = 1'b1;
        end else if (ready) begin
          exp[4] = 1'b1;
        end
      end else if (ready) begin
        if (d[3]) exp[6] = 1'b1;
        else exp[5] = 1'b1;
      end
    end
    return exp;
  endfunction

  task automatic check_all(input string tag, input logic [6:0] exp);
    check_eq({tag, ".strobes"}, {25'd0, dut_strobes()}, {25'd0, exp});
    check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, seen_icw1 && (pending.size() > 0)});
    check_eq({tag, ".sngl"}, {31'd0, sngl}, {31'd0, m_sngl});
    check_eq({tag, ".ic4"}, {31'd0, ic4}, {31'd0, m_ic4});
  endtask

  task automatic cycle(input string tag, input bit ws, input bit a0, input logic [7:0] d);
    logic [6:0] exp;
    @(negedge clock);
    write_strobe = ws;
    address_0 = a0;
    internal_data_bus = d;
    exp = model_write(ws, a0, d);
    @(posedge clock);
    #1;
    check_all(tag, exp);
  endtask

  task automatic wr(input string tag, input bit a0, input logic [7:0] d);
    cycle(tag, 1'b1, a0, d);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 8'h00);
  endtask

  // Reset asserted in the same cycle as a write: the write must be lost
  task automatic reset_with_write(input string tag);
    @(negedge clock);
    reset = 1'b1;
    write_strobe = 1'b1;
    address_0 = 1'b1;
    internal_data_bus = 8'h55;
    model_reset();
    @(posedge clock);
    #1;
    check_all(tag, 7'd0);
    @(negedge clock);
    reset = 1'b0;
    write_strobe = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    check_all("reset", 7'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single, with ICW4
    wr("s_icw1", 1'b0, 8'h13);
    wr("s_icw2", 1'b1, 8'h20);
    wr("s_icw4", 1'b1, 8'h01);
    idle("s_idle");

    // Cascade, with ICW3 and ICW4, then OCW1
    wr("c_icw1", 1'b0, 8'h11);
    wr("c_icw2", 1'b1, 8'h08);
    wr("c_icw3", 1'b1, 8'h04);
    wr("c_icw4", 1'b1, 8'h01);
    wr("c_ocw1", 1'b1, 8'hFF);

    // Single, no ICW4, then OCW2 / OCW3 back to back
    wr("n_icw1", 1'b0, 8'h12);
    wr("n_icw2", 1'b1, 8'h40);
    wr("n_ocw2", 1'b0, 8'h20);
    wr("n_ocw3", 1'b0, 8'h0B);
    wr("n_ocw1", 1'b1, 8'h33);

    // Uninitialized: everything but ICW1 ignored
    reset_with_write("u_reset");
    wr("u_data", 1'b1, 8'hFF);
    wr("u_ocw2", 1'b0, 8'h20);
    wr("u_ocw3", 1'b0, 8'h08);

    // Restart mid-sequence
    wr("r_icw1a", 1'b0, 8'h11);
    wr("r_icw2a", 1'b1, 8'h08);
    wr("r_ocw_ign", 1'b0, 8'h20);
    wr("r_icw1b", 1'b0, 8'h13);
    wr("r_icw2b", 1'b1, 8'h08);
    wr("r_icw4b", 1'b1, 8'h01);

    // Reset while waiting for ICW3, coincident with the ICW3 write
    wr("x_icw1", 1'b0, 8'h10);
    wr("x_icw2", 1'b1, 8'h08);
    reset_with_write("x_reset");
    wr("x_after", 1'b1, 8'h04);
    idle("x_idle");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_with_write("rnd_reset");
      end else begin
        logic [7:0] d;
        bit a0;
        d = 8'($urandom);
        a0 = 1'($urandom);
        // Make ICW1 rarer so sequences get a chance to complete
        if (!a0 && d[4] && $urandom_range(0, 2) != 0) d[4] = 1'b0;
        cycle("rnd", $urandom_range(0, 3) != 0, a0, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
